// File: rtl/bias_add_stage.sv
// Purpose: per-channel bias add with signed saturation behind a 2-cycle bias BRAM read.
// Latency: 3 cycles from input handshake to m_valid; one result per cycle when m_ready is held high.
// Backpressure: a single global advance (adv) freezes every stage, including the BRAM output pipe.
//
// Ports:
//   clk, rst_n              single clock (shared with BRAM port B), async active-low reset
//   s_valid/s_ready         input accumulator stream; s_data value, s_ch channel, s_last tile end
//   bram_addr/en/regce      bias read request toward BRAM port B; bram_dout returns 2 cycles later
//   m_valid/m_ready         result stream; m_data saturated acc+bias, m_last delayed s_last
//   sat_flag, ch_err        sticky status flags; clr_flags clears them synchronously
module bias_add_stage #(
    parameter int ACC_W  = 40,
    parameter int BIAS_W = 40,
    parameter int OUT_W  = 40,
    parameter int NUM_CH = 49,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [ACC_W-1:0]  s_data,
    input  logic [ADDR_W-1:0] s_ch,
    input  logic              s_last,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              bram_en,
    output logic              bram_regce,
    input  logic [BIAS_W-1:0] bram_dout,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [OUT_W-1:0]  m_data,
    output logic              m_last,
    output logic              sat_flag,
    output logic              ch_err,
    input  logic              clr_flags
);

    // Adder width: one guard bit above the wider operand; compare width also
    // covers OUT_W so the clip limits are representable.
    localparam int MAX_W = (ACC_W > BIAS_W) ? ACC_W : BIAS_W;
    localparam int SUM_W = MAX_W + 1;
    localparam int CMP_W = (SUM_W > OUT_W) ? SUM_W : OUT_W;

    localparam logic signed [CMP_W-1:0] OUT_MAX =
        {{(CMP_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [CMP_W-1:0] OUT_MIN =
        {{(CMP_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] OUT_MAX_W = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] OUT_MIN_W = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [ADDR_W:0]  NUM_CH_L  = (ADDR_W+1)'(NUM_CH);

    // Sideband that travels in lock-step with the bias read.
    typedef struct packed {
        logic [ACC_W-1:0] acc;
        logic             last;
        logic             bad;   // channel out of range: bias must be ignored
    } side_t;

    logic  adv;
    logic  v1, v2;
    side_t sb0, sb1, sb2;

    logic                     sat;
    logic [OUT_W-1:0]         res;
    logic [BIAS_W-1:0]        bias_eff;
    logic signed [CMP_W-1:0]  acc_x, bias_x, sum_c;
    logic                     set_sat, set_err;

    // Whole pipe moves together; output register empty or draining.
    assign adv        = !m_valid || m_ready;
    assign s_ready    = adv;
    assign bram_addr  = s_ch;
    // Gating en/regce with adv keeps the BRAM's internal latch and output
    // register frozen during a stall, so bias stays aligned with sb1/sb2.
    assign bram_en    = s_valid && adv;
    assign bram_regce = adv;

    always_comb begin
        sb0.acc  = s_data;
        sb0.last = s_last;
        sb0.bad  = ({1'b0, s_ch} >= NUM_CH_L);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1  <= 1'b0;
            v2  <= 1'b0;
            sb1 <= '0;
            sb2 <= '0;
        end else if (adv) begin
            v1  <= s_valid;
            sb1 <= sb0;
            v2  <= v1;
            sb2 <= sb1;
        end
    end

    // S3: add and clip. bram_dout holds the bias for the element now in S2.
    always_comb begin
        bias_eff = sb2.bad ? '0 : bram_dout;
        acc_x    = {{(CMP_W-ACC_W){sb2.acc[ACC_W-1]}}, sb2.acc};
        bias_x   = {{(CMP_W-BIAS_W){bias_eff[BIAS_W-1]}}, bias_eff};
        sum_c    = acc_x + bias_x;
        sat      = 1'b0;
        res      = sum_c[OUT_W-1:0];
        if (sum_c > OUT_MAX) begin
            sat = 1'b1;
            res = OUT_MAX_W;
        end else if (sum_c < OUT_MIN) begin
            sat = 1'b1;
            res = OUT_MIN_W;
        end
    end

    assign set_sat = adv && v2 && sat;
    assign set_err = adv && v2 && sb2.bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
        end else if (adv) begin
            m_valid <= v2;
            if (v2) begin
                m_data <= res;
                m_last <= sb2.last;
            end
        end
    end

    // Sticky flags: a new event in the same cycle beats the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_flag <= 1'b0;
            ch_err   <= 1'b0;
        end else begin
            if (set_sat)        sat_flag <= 1'b1;
            else if (clr_flags) sat_flag <= 1'b0;
            if (set_err)        ch_err   <= 1'b1;
            else if (clr_flags) ch_err   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bias_add_stage.sv
module tb_bias_add_stage;

    localparam int ACC_W  = 40;
    localparam int BIAS_W = 40;
    localparam int OUT_W  = 40;
    localparam int NUM_CH = 49;
    localparam int ADDR_W = 6;
    localparam longint MAXV = 64'sd549755813887;
    localparam longint MINV = -64'sd549755813888;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              s_valid   = 1'b0;
    logic              s_ready;
    logic [ACC_W-1:0]  s_data    = '0;
    logic [ADDR_W-1:0] s_ch      = '0;
    logic              s_last    = 1'b0;
    logic [ADDR_W-1:0] bram_addr;
    logic              bram_en;
    logic              bram_regce;
    logic [BIAS_W-1:0] bram_dout;
    logic              m_valid;
    logic              m_ready   = 1'b1;
    logic [OUT_W-1:0]  m_data;
    logic              m_last;
    logic              sat_flag;
    logic              ch_err;
    logic              clr_flags = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    bias_add_stage #(
        .ACC_W(ACC_W), .BIAS_W(BIAS_W), .OUT_W(OUT_W), .NUM_CH(NUM_CH), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_ch(s_ch), .s_last(s_last),
        .bram_addr(bram_addr), .bram_en(bram_en), .bram_regce(bram_regce), .bram_dout(bram_dout),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .sat_flag(sat_flag), .ch_err(ch_err), .clr_flags(clr_flags)
    );

    always #5 clk = ~clk;

    // Bias BRAM port B, 2-cycle read: en latches, regce registers the output.
    logic [BIAS_W-1:0] bram_mem [0:63];
    logic [BIAS_W-1:0] bram_lat;
    always @(posedge clk) begin
        if (bram_en)    bram_lat  <= bram_mem[bram_addr];
        if (bram_regce) bram_dout <= bram_lat;
    end

    typedef struct {
        logic [OUT_W-1:0] d;
        logic             l;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [OUT_W-1:0] model(input logic [ACC_W-1:0] acc, input logic [ADDR_W-1:0] ch);
        longint a, b, s;
        a = longint'($signed(acc));
        b = (ch < NUM_CH) ? longint'($signed(bram_mem[ch])) : 64'sd0;
        s = a + b;
        if (s > MAXV)      s = MAXV;
        else if (s < MINV) s = MINV;
        return s[OUT_W-1:0];
    endfunction

    // Downstream ready generator: 0 = always ready, 1 = 1-0-0-1 pattern, 2 = random.
    int         ready_mode = 0;
    int         cyc = 0;
    logic [3:0] pat = 4'b1001;
    always @(posedge clk) begin
        #1;
        cyc++;
        case (ready_mode)
            1:       m_ready = pat[cyc % 4];
            2:       m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b1;
        endcase
    end

    // Output monitor / scoreboard, sampled mid-cycle.
    int   out_cnt  = 0;
    int   run_len  = 0;
    int   max_run  = 0;
    logic prev_out = 1'b0;
    exp_t mon_e;
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_valid && !m_ready) begin
                chk("stall_bram_en", 64'(bram_en), 0);
                chk("stall_bram_regce", 64'(bram_regce), 0);
                chk("stall_s_ready", 64'(s_ready), 0);
            end
            if (m_valid && m_ready) begin
                out_cnt++;
                run_len = prev_out ? run_len + 1 : 1;
                if (run_len > max_run) max_run = run_len;
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("m_data", 64'(m_data), 64'(mon_e.d));
                    chk("m_last", 64'(m_last), 64'(mon_e.l));
                end
                prev_out = 1'b1;
            end else begin
                prev_out = 1'b0;
            end
        end else begin
            prev_out = 1'b0;
        end
    end

    // Present one element; returns 1ns after the accepting edge.
    task automatic send(input logic [ACC_W-1:0] acc, input logic [ADDR_W-1:0] ch, input logic last);
        logic ok;
        exp_t e;
        s_valid = 1'b1;
        s_data  = acc;
        s_ch    = ch;
        s_last  = last;
        ok      = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            ok = s_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            chk("send_timeout", 0, 1);
        end else begin
            e.d = model(acc, ch);
            e.l = last;
            exp_q.push_back(e);
        end
        s_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(posedge clk);
        if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        clr_flags = 1'b1;
        @(posedge clk);
        #1;
        clr_flags = 1'b0;
    endtask

    task automatic run8(input int mode, input string tag);
        int c0;
        longint a;
        c0 = out_cnt;
        max_run = 0;
        ready_mode = mode;
        for (int i = 0; i < 8; i++) begin
            a = (i % 2 == 1) ? -longint'(i * 300) : longint'(i * 4096 + 7);
            send(a[ACC_W-1:0], ADDR_W'(i), (i == 7));
        end
        drain();
        ready_mode = 0;
        chk({tag, "_count"}, 64'(out_cnt - c0), 8);
    endtask

    initial begin
        int k;
        int c0;

        for (int i = 0; i < 64; i++)
            bram_mem[i] = (i < NUM_CH) ? 40'(i * 'h111) : 40'hAB_CDEF_0123;
        bram_mem[3]  = 40'h00_0000_0010;
        bram_mem[10] = 40'h00_0000_0001;
        bram_mem[11] = 40'hFF_FFFF_FFFF;

        // Reset state
        @(posedge clk);
        #1;
        chk("rst_m_valid", 64'(m_valid), 0);
        chk("rst_s_ready", 64'(s_ready), 1);
        chk("rst_m_data", 64'(m_data), 0);
        chk("rst_m_last", 64'(m_last), 0);
        chk("rst_sat_flag", 64'(sat_flag), 0);
        chk("rst_ch_err", 64'(ch_err), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single element: 5 + bias[3]=0x10, visible 3 cycles after the handshake
        send(40'h00_0000_0005, 6'd3, 1'b0);
        k = 0;
        for (int i = 1; i <= 10 && k == 0; i++) begin
            @(negedge clk);
            if (m_valid) k = i;
        end
        chk("latency", 64'(k), 3);
        chk("single_m_data", 64'(m_data), 40'h00_0000_0015);
        drain();
        chk("single_sat_flag", 64'(sat_flag), 0);

        // Eight channels back-to-back, then with stalls
        run8(0, "b2b");
        chk("b2b_consecutive", 64'(max_run), 8);
        run8(1, "pat1001");
        run8(2, "random");
        chk("stream_sat_flag", 64'(sat_flag), 0);

        // Saturation boundaries
        send(40'h7F_FFFF_FFFE, 6'd10, 1'b0);
        drain();
        chk("edge_pos_data", 64'(m_data), 40'h7F_FFFF_FFFF);
        chk("edge_pos_sat", 64'(sat_flag), 0);
        send(40'h7F_FFFF_FFFF, 6'd10, 1'b0);
        drain();
        chk("sat_pos_data", 64'(m_data), 40'h7F_FFFF_FFFF);
        chk("sat_pos_flag", 64'(sat_flag), 1);
        pulse_clr();
        chk("sat_clr", 64'(sat_flag), 0);
        send(40'h80_0000_0000, 6'd11, 1'b1);
        drain();
        chk("sat_neg_data", 64'(m_data), 40'h80_0000_0000);
        chk("sat_neg_flag", 64'(sat_flag), 1);
        pulse_clr();

        // Out-of-range channel, with a clear landing on the same edge as the set
        chk("pre_ch_err", 64'(ch_err), 0);
        send(40'h00_0000_0020, 6'd55, 1'b0);
        @(posedge clk);
        #1;
        clr_flags = 1'b1;
        @(posedge clk);
        #1;
        clr_flags = 1'b0;
        chk("ch_err_set_wins", 64'(ch_err), 1);
        drain();
        chk("bad_ch_data", 64'(m_data), 40'h00_0000_0020);
        pulse_clr();
        chk("ch_err_clr", 64'(ch_err), 0);

        // Mid-stream reset with three elements in flight
        send(40'h1, 6'd1, 1'b0);
        send(40'h2, 6'd2, 1'b0);
        send(40'h3, 6'd3, 1'b1);
        chk("pre_reset_m_valid", 64'(m_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("async_m_valid", 64'(m_valid), 0);
        chk("async_m_data", 64'(m_data), 0);
        exp_q.delete();
        c0 = out_cnt;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("no_out_after_reset", 64'(out_cnt - c0), 0);
        send(40'h77, 6'd3, 1'b1);
        drain();
        chk("post_reset_count", 64'(out_cnt - c0), 1);
        chk("post_reset_data", 64'(m_data), 40'h00_0000_0087);
        chk("post_reset_last", 64'(m_last), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1, "watchdog timeout");
    end

endmodule
